// File: rtl/spi_sync_fifo.sv
// spi_sync_fifo: single-clock byte FIFO between the APB register block and the SPI shifter.
// Circular RAM with read/write pointers and an occupancy counter.
// DataOut is registered, so read data appears one cycle after the read is sampled.
// Full/empty come straight from the registered count, so no input reaches an output
// without passing through a flop.
// Optional build macro FIFO_STATUS_EN adds three status outputs:
//   level     - current occupancy
//   overflow  - sticky, set by a rejected write
//   underflow - sticky, set by a rejected read
// Both sticky flags clear only on reset.
// DEPTH must be a power of two (>= 2) so the pointers wrap by natural overflow.

module spi_sync_fifo #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned ADDR_WIDTH = $clog2(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_n,
    input  logic                  w_en,
    input  logic                  r_en,
    input  logic [DATA_WIDTH-1:0] DataIn,
    output logic [DATA_WIDTH-1:0] DataOut,
    output logic                  full,
    output logic                  empty
`ifdef FIFO_STATUS_EN
    ,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  overflow,
    output logic                  underflow
`endif
);

    localparam int unsigned CountWidth = ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH:0] FullCount = CountWidth'(DEPTH);

    // Storage is deliberately left unreset; stale contents are unreachable after
    // reset because both pointers and the count return to zero.
    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic [DATA_WIDTH-1:0] dout_q, dout_d;

    logic full_int;
    logic empty_int;
    logic r_accept;
    logic w_accept;

    // Flags derived from the registered count only.
    always_comb begin
        full_int  = (count_q == FullCount);
        empty_int = (count_q == '0);
    end

    // A read is honoured only when data is present; a write is honoured when there
    // is space or when an accepted read frees a slot on the same edge.
    // There is no bypass: when empty, the read is rejected even if a write arrives.
    always_comb begin
        r_accept = r_en && !empty_int;
        w_accept = w_en && (!full_int || r_accept);
    end

    // Next-state for pointers, occupancy and read data.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        dout_d   = dout_q;
        if (w_accept) begin
            wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
        end
        if (r_accept) begin
            rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
            dout_d   = mem[rd_ptr_q];
        end
        unique case ({w_accept, r_accept})
            2'b10:   count_d = count_q + CountWidth'(1);
            2'b01:   count_d = count_q - CountWidth'(1);
            default: count_d = count_q;
        endcase
    end

    // Control state with asynchronous active-low reset.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            dout_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            dout_q   <= dout_d;
        end
    end

    // Storage write port; no reset so it can map onto RAM.
    always_ff @(posedge clk_i) begin
        if (w_accept) begin
            mem[wr_ptr_q] <= DataIn;
        end
    end

    assign DataOut = dout_q;
    assign full    = full_int;
    assign empty   = empty_int;

`ifdef FIFO_STATUS_EN
    logic overflow_q, overflow_d;
    logic underflow_q, underflow_d;

    // Sticky error flags: set by any rejected request, held until reset.
    always_comb begin
        overflow_d  = overflow_q  | (w_en && !w_accept);
        underflow_d = underflow_q | (r_en && !r_accept);
    end

    // Status flag registers.
    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    assign level     = count_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`endif

endmodule

// File: tb/tb_spi_sync_fifo.sv
// Bench for spi_sync_fifo: a queue model predicts the result of every request.
// Each cycle the outputs are compared against the model one time unit after the edge.
// Build with FIFO_STATUS_EN to also check level/overflow/underflow.

module tb_spi_sync_fifo;

    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned AW    = $clog2(DEPTH);

    logic          clk_i;
    logic          rst_n;
    logic          w_en;
    logic          r_en;
    logic [DW-1:0] DataIn;
    logic [DW-1:0] DataOut;
    logic          full;
    logic          empty;
`ifdef FIFO_STATUS_EN
    logic [AW:0]   level;
    logic          overflow;
    logic          underflow;
`endif

    spi_sync_fifo #(
        .DATA_WIDTH(DW),
        .DEPTH     (DEPTH)
    ) dut (
        .clk_i  (clk_i),
        .rst_n  (rst_n),
        .w_en   (w_en),
        .r_en   (r_en),
        .DataIn (DataIn),
        .DataOut(DataOut),
        .full   (full),
        .empty  (empty)
`ifdef FIFO_STATUS_EN
        ,
        .level    (level),
        .overflow (overflow),
        .underflow(underflow)
`endif
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    // Scoreboard and model state
    logic [DW-1:0] mq[$];
    logic [DW-1:0] exp_out;
    bit            m_ovf;
    bit            m_unf;
    int            errors;
    int            checks;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, "/dout"},  32'(DataOut), 32'(exp_out));
        chk({tag, "/full"},  32'(full),    32'(mq.size() == DEPTH));
        chk({tag, "/empty"}, 32'(empty),   32'(mq.size() == 0));
`ifdef FIFO_STATUS_EN
        chk({tag, "/level"},     32'(level),     32'(mq.size()));
        chk({tag, "/overflow"},  32'(overflow),  32'(m_ovf));
        chk({tag, "/underflow"}, 32'(underflow), 32'(m_unf));
`endif
    endtask

    // One clock: drive the request, update the model, sample after the edge.
    task automatic cycle(input bit w, input bit r, input logic [DW-1:0] d, input string tag);
        bit r_acc;
        bit w_acc;
        w_en   = w;
        r_en   = r;
        DataIn = d;
        r_acc  = r && (mq.size() != 0);
        w_acc  = w && ((mq.size() < DEPTH) || r_acc);
        if (w && !w_acc) m_ovf = 1'b1;
        if (r && !r_acc) m_unf = 1'b1;
        if (r_acc) exp_out = mq.pop_front();
        if (w_acc) mq.push_back(d);
        @(posedge clk_i);
        #1;
        w_en = 1'b0;
        r_en = 1'b0;
        check_outputs(tag);
    endtask

    // Called 1 time unit after a rising edge; asserts reset mid-cycle for 5 ns.
    task automatic pulse_reset(input string tag);
        w_en = 1'b0;
        r_en = 1'b0;
        #2;
        rst_n = 1'b0;
        mq.delete();
        exp_out = '0;
        m_ovf   = 1'b0;
        m_unf   = 1'b0;
        #1;
        check_outputs({tag, "_async"});
        #4;
        rst_n = 1'b1;
        @(posedge clk_i);
        #1;
        check_outputs({tag, "_post"});
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_n  = 1'b1;
        w_en   = 1'b0;
        r_en   = 1'b0;
        DataIn = '0;
        exp_out = '0;
        m_ovf  = 1'b0;
        m_unf  = 1'b0;

        // Reset
        @(posedge clk_i);
        #1;
        pulse_reset("reset");

        // Fill: 20 writes, the last 4 dropped
        for (int i = 0; i < 20; i++) begin
            cycle(1'b1, 1'b0, DW'($urandom), "fill");
        end
        chk("fill_full_end", 32'(full), 32'd1);

        // Drain: 18 reads, the last 2 rejected
        for (int i = 0; i < 18; i++) begin
            cycle(1'b0, 1'b1, '0, "drain");
        end
        chk("drain_empty_end", 32'(empty), 32'd1);

        // Wrap
        for (int i = 0; i < 12; i++) cycle(1'b1, 1'b0, DW'(i), "wrap_w1");
        for (int i = 0; i < 12; i++) cycle(1'b0, 1'b1, '0, "wrap_r1");
        for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, DW'(8'h10 + i), "wrap_w2");
        chk("wrap_full", 32'(full), 32'd1);

        // Simultaneous at full: 0x10 leaves, 0xA5 goes in behind 0x1F
        cycle(1'b1, 1'b1, 8'hA5, "sim_full");
        chk("sim_full_dout", 32'(DataOut), 32'h10);
        chk("sim_full_flag", 32'(full), 32'd1);
        for (int i = 0; i < 16; i++) cycle(1'b0, 1'b1, '0, "wrap_r2");
        chk("sim_last_a5", 32'(DataOut), 32'hA5);

        // Simultaneous at empty: write only, DataOut unchanged
        cycle(1'b1, 1'b1, 8'h3C, "sim_empty");
        chk("sim_empty_flag", 32'(empty), 32'd0);
        chk("sim_empty_dout", 32'(DataOut), 32'hA5);
        cycle(1'b0, 1'b1, '0, "sim_empty_rd");
        chk("sim_empty_3c", 32'(DataOut), 32'h3C);

        // Reset mid-operation
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, DW'(8'h50 + i), "mid_w");
        pulse_reset("mid_reset");
        cycle(1'b0, 1'b1, '0, "mid_rd");
        chk("mid_rd_dout", 32'(DataOut), 32'h0);
        cycle(1'b0, 1'b0, '0, "idle");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
